tdm_demux_2ch: RTL and testbench

- Receives a 2-channel time-division-multiplexed sample stream, in which slot 0 = channel D0 and slot 1 = channel D1, and steers the samples back onto two parallel outputs.
- It is the receive-side counterpart of the 2:1 selector, with the select now driven by a slot sequence instead of an external S0.
- A small FSM handles frame alignment, stalls and sync errors.
- Outputs are registered and qualified by a one-cycle valid strobe. A wrapping frame counter is provided for bring-up visibility.

---
 rtl/dsd_pkg.sv | 13 +
 rtl/frame_counter.sv | 19 +
 rtl/tdm_demux_2ch.sv | 100 ++++++++++
 tb/tb_tdm_demux_2ch.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dsd_pkg.sv
// Shared definitions for the 2-channel TDM receive path: FSM encoding and default widths.
package dsd_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        EXP_CH1 = 2'b01,
        EXP_CH0 = 2'b10
    } state_t;

endpackage

// File: rtl/frame_counter.sv
// Wrapping event counter with enable and synchronous active-low clear.
module frame_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux_2ch.sv
// 2-channel TDM receiver: aligns on frame_sync, steers slot 0/1 onto dout0/dout1 with a valid strobe.
module tdm_demux_2ch
    import dsd_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic             dout_valid,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] hold0, hold0_nxt;
    logic [WIDTH-1:0] dout0_nxt, dout1_nxt;
    logic             dout_valid_nxt, sync_err_nxt;
    logic             frame_done_c;

    // State, channel-0 holding register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HUNT;
            hold0      <= '0;
            dout0      <= '0;
            dout1      <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold0      <= hold0_nxt;
            dout0      <= dout0_nxt;
            dout1      <= dout1_nxt;
            dout_valid <= dout_valid_nxt;
            sync_err   <= sync_err_nxt;
        end
    end

    // Slot sequencing; idle cycles leave everything but the strobes untouched
    always_comb begin
        state_nxt      = state;
        hold0_nxt      = hold0;
        dout0_nxt      = dout0;
        dout1_nxt      = dout1;
        dout_valid_nxt = 1'b0;
        sync_err_nxt   = 1'b0;
        frame_done_c   = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        hold0_nxt = din;
                        state_nxt = EXP_CH1;
                    end
                end
                EXP_CH1: begin
                    if (frame_sync) begin
                        // re-align on the newer slot-0 sample
                        sync_err_nxt = 1'b1;
                        hold0_nxt    = din;
                    end else begin
                        dout0_nxt      = hold0;
                        dout1_nxt      = din;
                        dout_valid_nxt = 1'b1;
                        frame_done_c   = 1'b1;
                        state_nxt      = EXP_CH0;
                    end
                end
                EXP_CH0: begin
                    if (frame_sync) begin
                        hold0_nxt = din;
                        state_nxt = EXP_CH1;
                    end else begin
                        sync_err_nxt = 1'b1;
                        state_nxt    = HUNT;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    frame_counter #(
        .W(CNT_W)
    ) u_frame_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (frame_done_c),
        .cnt   (frame_cnt)
    );

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Randomized self-checking bench for tdm_demux_2ch against a pending-sample reference model.
module tb_tdm_demux_2ch;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             frame_sync = 1'b0;
    logic [WIDTH-1:0] dout0, dout1;
    logic             dout_valid, sync_err;
    logic [CNT_W-1:0] frame_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    tdm_demux_2ch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout0      (dout0),
        .dout1      (dout1),
        .dout_valid (dout_valid),
        .sync_err   (sync_err),
        .frame_cnt  (frame_cnt)
    );

    // Model: a sync sample always opens a frame (error if one is already open);
    // a plain sample closes an open frame, else it is an error unless we are hunting.
    bit               m_pend, m_hunting;
    logic [WIDTH-1:0] m_pval, m_d0, m_d1;
    bit               m_v, m_err;
    logic [CNT_W-1:0] m_cnt;
    bit               n_pend, n_hunting, n_v, n_err;
    logic [WIDTH-1:0] n_pval, n_d0, n_d1;
    logic [CNT_W-1:0] n_cnt;

    always_comb begin
        n_pend = m_pend; n_hunting = m_hunting; n_pval = m_pval;
        n_d0 = m_d0; n_d1 = m_d1; n_cnt = m_cnt; n_v = 1'b0; n_err = 1'b0;
        if (!rst_n) begin
            n_pend = 1'b0; n_hunting = 1'b1; n_pval = '0;
            n_d0 = '0; n_d1 = '0; n_cnt = '0;
        end else if (din_valid) begin
            if (frame_sync) begin
                n_err = m_pend;
                n_pend = 1'b1; n_pval = din; n_hunting = 1'b0;
            end else if (m_pend) begin
                n_d0 = m_pval; n_d1 = din; n_v = 1'b1;
                n_cnt = CNT_W'(m_cnt + 1'b1); n_pend = 1'b0;
            end else if (!m_hunting) begin
                n_err = 1'b1; n_hunting = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        m_pend <= n_pend; m_hunting <= n_hunting; m_pval <= n_pval;
        m_d0 <= n_d0; m_d1 <= n_d1; m_cnt <= n_cnt; m_v <= n_v; m_err <= n_err;
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (dout0 !== m_d0 || dout1 !== m_d1 || dout_valid !== m_v ||
                sync_err !== m_err || frame_cnt !== m_cnt) begin
                miscompares++;
                $display("FAIL model t=%0t got d0=%h d1=%h v=%b err=%b cnt=%0d want d0=%h d1=%h v=%b err=%b cnt=%0d",
                         $time, dout0, dout1, dout_valid, sync_err, frame_cnt,
                         m_d0, m_d1, m_v, m_err, m_cnt);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic smp(input logic [WIDTH-1:0] d, input bit s);
        @(negedge clk);
        din = d; din_valid = 1'b1; frame_sync = s;
    endtask

    task automatic nop();
        @(negedge clk);
        din = WIDTH'($urandom); din_valid = 1'b0; frame_sync = 1'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst_n = 1'b1;
        check("rst_dout0", 32'(dout0), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_cnt", 32'(frame_cnt), 32'h0);

        // Basic pair
        smp(8'hA5, 1'b1); smp(8'h3C, 1'b0); nop();
        check("t1_valid", 32'(dout_valid), 32'h1);
        check("t1_dout0", 32'(dout0), 32'hA5);
        check("t1_dout1", 32'(dout1), 32'h3C);
        check("t1_cnt", 32'(frame_cnt), 32'h1);
        nop();
        check("t1_pulse", 32'(dout_valid), 32'h0);

        // Stall in mid-frame
        do_reset();
        smp(8'h11, 1'b1);
        for (int i = 0; i < 5; i++) begin
            nop();
            check("t2_stall", 32'({dout_valid, sync_err}), 32'h0);
        end
        smp(8'h22, 1'b0); nop();
        check("t2_pair", 32'({dout_valid, sync_err, dout0, dout1}), 32'h21122);

        // Misalignment from reset
        do_reset();
        smp(8'h77, 1'b0); smp(8'h88, 1'b0); nop();
        check("t3_noerr", 32'(sync_err), 32'h0);
        smp(8'h99, 1'b1); smp(8'hAA, 1'b0); nop();
        check("t3_pair", 32'({dout_valid, dout0, dout1}), 32'h199AA);

        // Double sync
        do_reset();
        smp(8'h01, 1'b1); smp(8'h02, 1'b1); nop();
        check("t4_err", 32'(sync_err), 32'h1);
        smp(8'h03, 1'b0); nop();
        check("t4_pair", 32'({dout_valid, sync_err, dout0, dout1, frame_cnt}), 32'h2020301);

        // Missing sync
        smp(8'h05, 1'b0); nop();
        check("t5_err", 32'({dout_valid, sync_err}), 32'h1);
        smp(8'h06, 1'b1); smp(8'h07, 1'b0); nop();
        check("t5_pair", 32'({dout_valid, dout0, dout1}), 32'h10607);

        // Reset mid-frame discards the half pair
        smp(8'hF0, 1'b1);
        do_reset();
        smp(8'h0F, 1'b0); nop();
        check("t6_clear", 32'({dout_valid, sync_err, dout0, dout1, frame_cnt}), 32'h0);

        // Counter wrap, back-to-back frames
        for (int i = 0; i < 255; i++) begin
            smp(WIDTH'(i), 1'b1); smp(WIDTH'(~i), 1'b0);
        end
        nop();
        check("t6_cnt255", 32'(frame_cnt), 32'hFF);
        smp(8'h12, 1'b1); smp(8'h34, 1'b0); nop();
        check("t6_wrap", 32'(frame_cnt), 32'h0);

        // Randomized traffic with mostly correct slot order and rare resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            din = WIDTH'($urandom);
            din_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) frame_sync = 1'($urandom);
            else frame_sync = ~frame_sync;
        end
        @(negedge clk);
        rst_n = 1'b1; din_valid = 1'b0;
        nop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
